// File: rtl/store_unit.sv
// Store unit: turns byte/halfword/word stores into lane-positioned memory write beats.
// Define STORE_UNIT_SPLIT_EN to accept misaligned stores (word-crossing ones take two beats).
module store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        err
);

`ifdef STORE_UNIT_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FAIL} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [3:0]  req_mask, st_mask;
  logic [1:0]  req_off, st_off;
  logic        misaligned, illegal, need_beat1;
  logic [3:0]  st_be_hi;
  logic [31:0] st_wdata_hi;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 4'h1;
      2'b01:   size_mask = 4'h3;
      2'b10:   size_mask = 4'hF;
      default: size_mask = 4'h0;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE);
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    req_off    = req_addr[1:0];
    req_mask   = size_mask(req_size);
    misaligned = ((req_size == 2'b01) && req_off[0]) || ((req_size == 2'b10) && (req_off != 2'b00));
    illegal    = (req_size == 2'b11) || (!SPLIT_EN && misaligned);

    // Second-beat lanes are the bits that spill past byte 3 of the shifted store.
    st_off      = addr_q[1:0];
    st_mask     = size_mask(size_q);
    st_be_hi    = st_mask >> (3'd4 - {1'b0, st_off});
    st_wdata_hi = data_q >> (6'd32 - {1'b0, st_off, 3'b000});
    need_beat1  = SPLIT_EN && (st_be_hi != 4'h0);

    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    size_d      = size_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          data_d = req_data;
          size_d = req_size;
          if (illegal) begin
            state_d = FAIL;
            err_d   = 1'b1;
          end else begin
            state_d     = BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = req_data << {req_off, 3'b000};
            mem_be_d    = req_mask << req_off;
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (need_beat1) begin
            state_d     = BEAT1;
            mem_addr_d  = {addr_q[31:2], 2'b00} + 32'd4;
            mem_wdata_d = st_wdata_hi;
            mem_be_d    = st_be_hi;
          end else begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            mem_addr_d  = 32'h0;
            mem_wdata_d = 32'h0;
            mem_be_d    = 4'h0;
            done_d      = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          mem_addr_d  = 32'h0;
          mem_wdata_d = 32'h0;
          mem_be_d    = 4'h0;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      data_q      <= 32'h0;
      size_q      <= 2'b00;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      size_q      <= size_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: req_valid  input  1  store request present.
REQ-004 SHALL have port: req_ready  output  1  unit can accept a request.
REQ-005 SHALL have port: req_addr  input  32  byte address of store.
REQ-006 SHALL have port: req_data  input  32  register value; low bits hold the byte or halfword.
REQ-007 SHALL have port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port: mem_valid  output  1  memory write beat present.
REQ-009 SHALL have port: mem_ready  input  1  memory accepts beat.
REQ-010 SHALL have port: mem_addr  output  32  word address, bits [1:0] always 00.
REQ-011 SHALL have port: mem_wdata  output  32  lane-positioned write data.
REQ-012 SHALL have port: mem_be  output  4  byte enables; bit i covers mem_wdata[8i+7:8i].
REQ-013 SHALL have port: done  output  1  one-cycle pulse: store completed.
REQ-014 SHALL have port: err  output  1  one-cycle pulse: store rejected; no memory beat issued.

Function
REQ-015 SHALL use little-endian lanes: off = req_addr[1:0]; mask = 1, 3, F for byte, half, word.
REQ-016 SHALL implement FSM states IDLE, BEAT0, BEAT1, FAIL.
REQ-017 SHALL assert req_ready only in IDLE.
REQ-018 SHALL register addr, data, size on req_valid&&req_ready.
REQ-019 SHALL move IDLE->FAIL when the accepted request is illegal (REQ-027/028); otherwise IDLE->BEAT0.
REQ-020 SHALL, in BEAT0, drive mem_valid=1, mem_addr={addr[31:2],00}, mem_wdata=data<<(8*off), mem_be=(mask<<off)[3:0].
REQ-021 SHALL hold mem_valid, mem_addr, mem_wdata and mem_be stable until the cycle mem_valid&&mem_ready.
REQ-022 SHALL, on the BEAT0 handshake, go to BEAT1 if (mask<<off)[7:4]!=0, else to IDLE.
REQ-023 SHALL, in BEAT1, drive mem_addr={addr[31:2],00}+4, mem_wdata=data>>(8*(4-off)), mem_be=(mask<<off)[7:4]; go to IDLE on handshake.
REQ-024 SHALL pulse done in the cycle after the final beat handshake; FSM is then in IDLE (back-to-back accept allowed in that cycle).
REQ-025 SHALL, from FAIL, pulse err that cycle and return to IDLE next cycle.
REQ-026 SHALL give latency: accept at T -> mem_valid at T+1 -> with mem_ready at T+1, done and req_ready at T+2.
REQ-027 SHALL treat req_size=11 as illegal in all configurations.
REQ-028 SHALL treat a store as misaligned when halfword with off[0]=1 or word with off!=0.
REQ-029 SHALL drive mem_valid=0, mem_be=0, mem_addr=0 and mem_wdata=0 outside BEAT0/BEAT1.
REQ-030 SHALL ignore req_valid while req_ready=0 (no queuing).

Reset
REQ-031 SHALL, while reset=0, force FSM to IDLE and drive req_ready=1 and mem_valid, mem_be, mem_addr, mem_wdata, done and err to 0, all registered fields to 0.
REQ-032 SHALL abandon any in-flight beat on reset assertion mid-operation; no done or err pulses for it.
REQ-033 SHALL accept a request in the first clock edge after reset deassertion.

Configuration
REQ-034 SHALL recognise macro STORE_UNIT_SPLIT_EN.
REQ-035 SHALL, with STORE_UNIT_SPLIT_EN defined, not treat misaligned stores as illegal: in-word misaligned issue one beat, word-crossing issue two beats per REQ-020..023.
REQ-036 SHALL, without STORE_UNIT_SPLIT_EN, treat misaligned stores as illegal (FAIL, err, no beat) and never enter BEAT1.

Verification
REQ-037 SHALL cover: byte store addr=0x1002, data=0x000000AB, mem_ready=1 -> one beat addr=0x1000, wdata=0x00AB0000, be=0100, done at T+2.
REQ-038 SHALL cover: word store addr=0x2000, data=0xDEADBEEF, mem_ready low 3 cycles -> beat held stable 4 cycles, be=1111, single done after handshake.
REQ-039 SHALL cover: halfword addr=0x3003, data=0x0000CAFE; SPLIT_EN -> beats (0x3000, 0xFE000000, 1000) then (0x3004, 0x000000CA, 0001), done; without -> err at T+1, no mem_valid.
REQ-040 SHALL cover: req_size=11 any address -> err pulse at T+1, no mem_valid, req_ready=1 at T+2.
REQ-041 SHALL cover: reset=0 asserted during BEAT0 with mem_ready=0 -> mem_valid=0 immediately, no done; after release, new word store completes normally.
REQ-042 SHALL cover: two back-to-back byte stores with req_valid held high and mem_ready=1 -> second accepted in the done cycle; beats 2 cycles apart.
